beta_csr_access_unit: RTL

BETA_CSR_ACCESS_UNIT -- requirements
Module: beta_csr_access_unit

---
 rtl/beta_csr_access_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/beta_csr_access_unit.sv
// rtl/beta_csr_access_unit.sv - Zicsr instruction sequencer: decode, privilege check, one-cycle CSR access, held response
module beta_csr_access_unit #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_funct3_i,
  input  logic [4:0]           req_rs1_idx_i,
  input  logic [DataWidth-1:0] req_rs1_data_i,
  input  logic [4:0]           req_rd_idx_i,
  input  logic [11:0]          req_csr_addr_i,
  input  logic [1:0]           priv_lvl_i,
  output logic [11:0]          csr_addr_o,
  output logic [DataWidth-1:0] csr_wdata_o,
  output logic [2:0]           csr_op_o,
  output logic                 csr_en_o,
  input  logic [DataWidth-1:0] csr_rdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4:0]           rsp_rd_idx_o,
  output logic [DataWidth-1:0] rsp_rd_data_o,
  output logic                 rsp_rd_we_o,
  output logic                 rsp_illegal_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e state_q, state_d;

  logic [11:0]          addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [2:0]           op_q;
  logic [4:0]           rd_idx_q;
  logic                 illegal_q;
  logic                 rd_we_q;
  logic [DataWidth-1:0] rd_data_q;

  logic [1:0]           kind;
  logic                 wr_eff;
  logic                 rd_eff;
  logic                 illegal;
  logic [2:0]           op;
  logic [DataWidth-1:0] operand;
  logic                 handshake;

  // funct3[1:0] selects RW/RS/RC, funct3[2] selects the immediate form
  always_comb begin
    kind    = req_funct3_i[1:0];
    operand = req_funct3_i[2] ? DataWidth'(req_rs1_idx_i) : req_rs1_data_i;
    wr_eff  = (kind == 2'b01) || (req_rs1_idx_i != 5'd0);
    rd_eff  = !((kind == 2'b01) && (req_rd_idx_i == 5'd0));
    op      = 3'b000;
    op[2]   = rd_eff;
    case (kind)
      2'b01:   op[1:0] = 2'b11;
      2'b10:   op[1:0] = 2'b01;
      2'b11:   op[1:0] = 2'b10;
      default: op[1:0] = 2'b00;
    endcase
    if (!wr_eff) op[1:0] = 2'b00;
    illegal = (kind == 2'b00) || (priv_lvl_i < req_csr_addr_i[9:8]) ||
              (wr_eff && (req_csr_addr_i[11:10] == 2'b11));
  end

  assign req_ready_o = (state_q == IDLE);
  assign handshake   = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = illegal ? RESP : ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      rd_idx_q  <= '0;
      illegal_q <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        addr_q    <= req_csr_addr_i;
        wdata_q   <= operand;
        op_q      <= op;
        rd_idx_q  <= req_rd_idx_i;
        illegal_q <= illegal;
        rd_we_q   <= !illegal && (req_rd_idx_i != 5'd0);
        rd_data_q <= '0;
      end
      // CSR file returns the pre-write value combinationally during ISSUE
      if (state_q == ISSUE) rd_data_q <= csr_rdata_i;
    end
  end

  assign csr_en_o      = (state_q == ISSUE);
  assign csr_op_o      = (state_q == ISSUE) ? op_q : 3'b000;
  assign csr_addr_o    = addr_q;
  assign csr_wdata_o   = wdata_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rd_idx_o  = rd_idx_q;
  assign rsp_rd_data_o = rd_data_q;
  assign rsp_rd_we_o   = rd_we_q;
  assign rsp_illegal_o = illegal_q;

endmodule
